kernel_nios2_gen2_0_cpu_mult_seq: RTL and testbench

Multi-cycle multiply sequencer for the Nios II kernel core. It drives the 16x16 partial-product multiplier cell over its operand and enable interface, and consumes the cell's three registered partial products. From those it assembles the low or high 32-bit word of a 32x32 product. It sits between the execute-stage request path and the cell and returns results over a valid/ready handshake. It supports MUL, MULXUU, MULXSU and MULXSS.

---
 rtl/kernel_nios2_gen2_0_cpu_mult_pkg.sv | 24 ++
 rtl/kernel_nios2_gen2_0_cpu_mult_sum.sv | 32 +++
 rtl/kernel_nios2_gen2_0_cpu_mult_seq.sv | 112 +++++++++++
 tb/tb_kernel_nios2_gen2_0_cpu_mult_seq.sv | 162 ++++++++++++++++
 4 files changed

// File: rtl/kernel_nios2_gen2_0_cpu_mult_pkg.sv
// Shared definitions for the Nios II kernel multiply sequencer: op codes,
// FSM states and partial-product widths.
package kernel_nios2_gen2_0_cpu_mult_pkg;

    localparam int PP_W   = 32;
    localparam int HALF_W = 16;

    typedef enum logic [1:0] {
        OP_MUL    = 2'b00,
        OP_MULXUU = 2'b01,
        OP_MULXSU = 2'b10,
        OP_MULXSS = 2'b11
    } mul_op_e;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ISS0  = 3'd1,
        ST_WAIT0 = 3'd2,
        ST_WAIT1 = 3'd3,
        ST_SUM   = 3'd4,
        ST_RESP  = 3'd5
    } mult_state_e;

endpackage

// File: rtl/kernel_nios2_gen2_0_cpu_mult_sum.sv
// Combines the four 16x16 partial products into a 64-bit product and applies
// the two's-complement correction for the signed high-word ops.
module kernel_nios2_gen2_0_cpu_mult_sum
    import kernel_nios2_gen2_0_cpu_mult_pkg::*;
(
    input  logic [PP_W-1:0]   ll_i,
    input  logic [PP_W-1:0]   lh_i,
    input  logic [PP_W-1:0]   hl_i,
    input  logic [PP_W-1:0]   hh_i,
    input  mul_op_e           op_i,
    input  logic [PP_W-1:0]   a_i,
    input  logic [PP_W-1:0]   b_i,
    output logic [2*PP_W-1:0] prod_o
);

    logic [PP_W:0]     mid;
    logic [2*PP_W-1:0] prod;

    always_comb begin
        // Cross terms summed at 33 bits so their carry reaches bit 48
        mid  = {1'b0, lh_i} + {1'b0, hl_i};
        prod = {{PP_W{1'b0}}, ll_i}
             + {{(PP_W-HALF_W-1){1'b0}}, mid, {HALF_W{1'b0}}}
             + {hh_i, {PP_W{1'b0}}};
        if ((op_i == OP_MULXSU || op_i == OP_MULXSS) && a_i[PP_W-1])
            prod = prod - {b_i, {PP_W{1'b0}}};
        if (op_i == OP_MULXSS && b_i[PP_W-1])
            prod = prod - {a_i, {PP_W{1'b0}}};
        prod_o = prod;
    end

endmodule

// File: rtl/kernel_nios2_gen2_0_cpu_mult_seq.sv
// Multi-cycle multiply sequencer: issues operands to the external 16x16 cell,
// gathers its partial products and returns the low or high product word.
module kernel_nios2_gen2_0_cpu_mult_seq
    import kernel_nios2_gen2_0_cpu_mult_pkg::*;
(
    input  logic            clk,
    input  logic            reset_n,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [1:0]      req_op,
    input  logic [PP_W-1:0] req_a,
    input  logic [PP_W-1:0] req_b,
    output logic            resp_valid,
    input  logic            resp_ready,
    output logic [PP_W-1:0] resp_data,
    output logic [PP_W-1:0] cell_src1,
    output logic [PP_W-1:0] cell_src2,
    output logic            cell_en,
    input  logic [PP_W-1:0] cell_p1,
    input  logic [PP_W-1:0] cell_p2,
    input  logic [PP_W-1:0] cell_p3
);

    mult_state_e       state_q, state_d;
    mul_op_e           op_q;
    logic [PP_W-1:0]   a_q, b_q;
    logic [PP_W-1:0]   ll_q, lh_q, hl_q, hh_q;
    logic [PP_W-1:0]   resp_data_q;
    logic [2*PP_W-1:0] prod;

    kernel_nios2_gen2_0_cpu_mult_sum u_sum (
        .ll_i   (ll_q),
        .lh_i   (lh_q),
        .hl_i   (hl_q),
        .hh_i   (hh_q),
        .op_i   (op_q),
        .a_i    (a_q),
        .b_i    (b_q),
        .prod_o (prod)
    );

    always_comb begin
        state_d    = state_q;
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        cell_en    = 1'b0;
        cell_src1  = '0;
        cell_src2  = '0;
        case (state_q)
            ST_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) state_d = ST_ISS0;
            end
            ST_ISS0: begin
                cell_en   = 1'b1;
                cell_src1 = a_q;
                cell_src2 = b_q;
                state_d   = ST_WAIT0;
            end
            ST_WAIT0: begin
                if (op_q == OP_MUL) begin
                    state_d = ST_SUM;
                end else begin
                    // Half-swapped operands make the cell's next p1 equal a_hi*b_hi
                    cell_en   = 1'b1;
                    cell_src1 = {a_q[HALF_W-1:0], a_q[PP_W-1:HALF_W]};
                    cell_src2 = {b_q[HALF_W-1:0], b_q[PP_W-1:HALF_W]};
                    state_d   = ST_WAIT1;
                end
            end
            ST_WAIT1: state_d = ST_SUM;
            ST_SUM:   state_d = ST_RESP;
            ST_RESP: begin
                resp_valid = 1'b1;
                if (resp_ready) state_d = ST_IDLE;
            end
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            op_q        <= OP_MUL;
            a_q         <= '0;
            b_q         <= '0;
            ll_q        <= '0;
            lh_q        <= '0;
            hl_q        <= '0;
            hh_q        <= '0;
            resp_data_q <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == ST_IDLE && req_valid) begin
                op_q <= mul_op_e'(req_op);
                a_q  <= req_a;
                b_q  <= req_b;
            end
            if (state_q == ST_WAIT0) begin
                ll_q <= cell_p1;
                lh_q <= cell_p2;
                hl_q <= cell_p3;
            end
            if (state_q == ST_WAIT1) hh_q <= cell_p1;
            if (state_q == ST_SUM)
                resp_data_q <= (op_q == OP_MUL) ? prod[PP_W-1:0] : prod[2*PP_W-1:PP_W];
        end
    end

    assign resp_data = resp_data_q;

endmodule

// File: tb/tb_kernel_nios2_gen2_0_cpu_mult_seq.sv
// Directed bench for the multiply sequencer with a behavioural 16x16 cell.
module tb_kernel_nios2_gen2_0_cpu_mult_seq;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [1:0]  req_op = 2'b00;
    logic [31:0] req_a = '0;
    logic [31:0] req_b = '0;
    logic        resp_valid;
    logic        resp_ready = 1'b1;
    logic [31:0] resp_data;
    logic [31:0] cell_src1, cell_src2;
    logic        cell_en;
    logic [31:0] cell_p1, cell_p2, cell_p3;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    kernel_nios2_gen2_0_cpu_mult_seq dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op     (req_op),
        .req_a      (req_a),
        .req_b      (req_b),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_data  (resp_data),
        .cell_src1  (cell_src1),
        .cell_src2  (cell_src2),
        .cell_en    (cell_en),
        .cell_p1    (cell_p1),
        .cell_p2    (cell_p2),
        .cell_p3    (cell_p3)
    );

    // Behavioural partial-product cell, one-cycle latency, cleared by reset
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cell_p1 <= '0;
            cell_p2 <= '0;
            cell_p3 <= '0;
        end else if (cell_en) begin
            cell_p1 <= 32'(cell_src1[15:0])  * 32'(cell_src2[15:0]);
            cell_p2 <= 32'(cell_src1[15:0])  * 32'(cell_src2[31:16]);
            cell_p3 <= 32'(cell_src1[31:16]) * 32'(cell_src2[15:0]);
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Caller is at a negedge with the DUT idle
    task automatic do_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp, input int stall);
        int n;
        int en_cnt;
        int lat;
        lat = (op == 2'b00) ? 4 : 5;
        req_op = op; req_a = a; req_b = b; req_valid = 1'b1;
        resp_ready = (stall == 0);
        check({tag, "_req_ready"}, 32'(req_ready), 32'd1);
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        n = 1;
        en_cnt = 0;
        check({tag, "_iss0_en"}, 32'(cell_en), 32'd1);
        while (!resp_valid && n < 16) begin
            if (cell_en) begin
                en_cnt++;
                if (n == 2) begin
                    check({tag, "_swap1"}, cell_src1, {a[15:0], a[31:16]});
                    check({tag, "_swap2"}, cell_src2, {b[15:0], b[31:16]});
                end else if (n == 1) begin
                    check({tag, "_src1"}, cell_src1, a);
                    check({tag, "_src2"}, cell_src2, b);
                end
            end
            @(negedge clk);
            n++;
        end
        check({tag, "_latency"}, 32'(n), 32'(lat));
        check({tag, "_en_count"}, 32'(en_cnt), (op == 2'b00) ? 32'd1 : 32'd2);
        check({tag, "_data"}, resp_data, exp);
        for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            check({tag, "_stall_valid"}, 32'(resp_valid), 32'd1);
            check({tag, "_stall_data"}, resp_data, exp);
            check({tag, "_stall_ready"}, 32'(req_ready), 32'd0);
        end
        resp_ready = 1'b1;
        @(negedge clk);
        check({tag, "_idle_valid"}, 32'(resp_valid), 32'd0);
        check({tag, "_idle_ready"}, 32'(req_ready), 32'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        #1;
        check("rst_req_ready", 32'(req_ready), 32'd1);
        check("rst_resp_valid", 32'(resp_valid), 32'd0);
        check("rst_resp_data", resp_data, 32'd0);
        check("rst_cell_en", 32'(cell_en), 32'd0);
        check("rst_src1", cell_src1, 32'd0);
        check("rst_src2", cell_src2, 32'd0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);

        do_op("mul_ff",    2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 0);
        do_op("mulxuu_ff", 2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 0);
        do_op("mulxsu_ff", 2'b10, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 0);
        do_op("mulxss_ff", 2'b11, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 0);
        do_op("mulxuu_80", 2'b01, 32'h80000000, 32'h80000000, 32'h40000000, 0);
        do_op("mulxsu_80", 2'b10, 32'h80000000, 32'h80000000, 32'hC0000000, 0);
        do_op("mulxss_80", 2'b11, 32'h80000000, 32'h80000000, 32'h40000000, 0);
        do_op("mulxuu_1",  2'b01, 32'h00010000, 32'h00010000, 32'h00000001, 0);
        do_op("mul_1",     2'b00, 32'h00010000, 32'h00010000, 32'h00000000, 0);
        do_op("bp_mulxss", 2'b11, 32'h00001234, 32'hFFFFFFFE, 32'hFFFFFFFF, 5);
        do_op("b2b_mul",   2'b00, 32'h00001234, 32'h00000010, 32'h00012340, 0);

        // Abort a high-word op in WAIT0, while the cell is being re-issued
        req_op = 2'b01; req_a = 32'h12345678; req_b = 32'h9ABCDEF0; req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(posedge clk);
        #2;
        check("wait0_en", 32'(cell_en), 32'd1);
        reset_n = 1'b0;
        #1;
        check("arst_cell_en", 32'(cell_en), 32'd0);
        check("arst_src1", cell_src1, 32'd0);
        check("arst_src2", cell_src2, 32'd0);
        check("arst_req_ready", 32'(req_ready), 32'd1);
        check("arst_resp_valid", 32'(resp_valid), 32'd0);
        check("arst_resp_data", resp_data, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        do_op("post_rst_mul", 2'b00, 32'd3, 32'd5, 32'h0000000F, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
